// File: rtl/wb_mem_pkg.sv
// Shared types, constants and helpers for the wait-state Wishbone memory.
package wb_mem_pkg;

   // Data-port sequencer states; WAIT is only reachable when DATA_LATENCY > 1.
   typedef enum logic [0:0] {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   localparam int unsigned WB_SEL_W    = 4;
   localparam int unsigned MAX_LATENCY = 8;
   // Wait counter holds DATA_LATENCY-1 at most.
   localparam int unsigned CNT_W       = $clog2(MAX_LATENCY);

   // A byte address is backed by storage iff it lies below the memory size.
   function automatic logic in_range(input logic [63:0] addr, input int unsigned bytes);
      return addr < 64'(bytes);
   endfunction

endpackage

// File: rtl/mem_array_2p.sv
// Word-organised storage: one read-only port (instruction) and one
// read/write port (data) with per-byte write enables. Reads are combinational,
// so a register sampling a read port at a write edge captures the old word.
module mem_array_2p
   import wb_mem_pkg::*;
#(
   parameter int unsigned WORDS = 1024,
   parameter int unsigned IDX_W = 10
) (
   input  logic                clk,
   input  logic [IDX_W-1:0]    a_idx,
   output logic [31:0]         a_rd_data,
   input  logic [IDX_W-1:0]    b_idx,
   input  logic                b_wr_en,
   input  logic [WB_SEL_W-1:0] b_wr_sel,
   input  logic [31:0]         b_wr_data,
   output logic [31:0]         b_rd_data
);

   logic [31:0] mem_q [WORDS];

   assign a_rd_data = mem_q[a_idx];
   assign b_rd_data = mem_q[b_idx];

   // Byte-lane write on the data port.
   // NOTE: the array has no reset; contents survive rst_n so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (b_wr_en) begin
         for (int b = 0; b < WB_SEL_W; b++) begin
            if (b_wr_sel[b]) mem_q[b_idx][8*b +: 8] <= b_wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/wb_wait_memory.sv
// Unified instruction/data memory. Instruction port answers in one cycle;
// data port is Wishbone-pipelined with DATA_LATENCY cycles from accepted
// strobe to ack/err, stalling while an access is in flight.
module wb_wait_memory
   import wb_mem_pkg::*;
#(
   parameter int unsigned MEMORY_BYTES = 4096,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] instr_addr,
   input  logic                  instr_stb,
   output logic [31:0]           instr,
   output logic                  instr_ack,
   output logic                  instr_err,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_wr_en,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [31:0]           wb_wr_data,
   input  logic [WB_SEL_W-1:0]   wb_wr_sel,
   output logic                  wb_ack,
   output logic                  wb_err,
   output logic                  wb_stall,
   output logic [31:0]           wb_rd_data
);

   localparam int unsigned WORDS = MEMORY_BYTES / 4;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   mem_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic             wr_en_q;
   logic             in_range_q;
   logic [31:0]      instr_q;
   logic             instr_ack_q;
   logic             instr_err_q;
   logic             wb_ack_q;
   logic             wb_err_q;
   logic [31:0]      wb_rd_data_q;
   logic [31:0]      wb_rd_data_d;

   logic             instr_ok;
   logic             wb_ok;
   logic             accept;
   logic             fin;
   logic             fin_ok;
   logic             fin_wr;
   logic             mem_wr_en;
   logic [IDX_W-1:0] instr_idx;
   logic [IDX_W-1:0] wb_idx;
   logic [IDX_W-1:0] data_idx;
   logic [31:0]      instr_word;
   logic [31:0]      data_word;

   assign instr_ok  = in_range(64'(instr_addr), MEMORY_BYTES);
   assign wb_ok     = in_range(64'(wb_addr), MEMORY_BYTES);
   assign instr_idx = instr_addr[IDX_W+1:2];
   assign wb_idx    = wb_addr[IDX_W+1:2];

   // Stall only while a multi-cycle access is in flight; low in reset (state IDLE).
   assign wb_stall  = (DATA_LATENCY > 1) && (state_q == MEM_WAIT);
   assign accept    = wb_cyc & wb_stb & ~wb_stall;

   // Completion: same edge as acceptance for latency 1, else when the count runs out.
   assign fin    = (DATA_LATENCY == 1) ? accept
                 : ((state_q == MEM_WAIT) && wb_cyc && (cnt_q == CNT_W'(1)));
   assign fin_ok = (DATA_LATENCY == 1) ? wb_ok    : in_range_q;
   assign fin_wr = (DATA_LATENCY == 1) ? wb_wr_en : wr_en_q;

   // While waiting the data port points at the latched word for the final read.
   assign data_idx     = (state_q == MEM_WAIT) ? idx_q : wb_idx;
   assign mem_wr_en    = accept & wb_wr_en & wb_ok;
   assign wb_rd_data_d = fin_ok ? data_word : '0;

   mem_array_2p #(
      .WORDS (WORDS),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk       (clk),
      .a_idx     (instr_idx),
      .a_rd_data (instr_word),
      .b_idx     (data_idx),
      .b_wr_en   (mem_wr_en),
      .b_wr_sel  (wb_wr_sel),
      .b_wr_data (wb_wr_data),
      .b_rd_data (data_word)
   );

   // Instruction port: fixed one-cycle registered read, zero when out of range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q     <= '0;
         instr_ack_q <= 1'b0;
         instr_err_q <= 1'b0;
      end else begin
         instr_q     <= instr_ok ? instr_word : '0;
         instr_ack_q <= instr_stb;
         instr_err_q <= instr_stb & ~instr_ok;
      end
   end

   // Data-port sequencer: latch request, count wait states, pulse ack/err, load read data.
   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= MEM_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         wr_en_q      <= 1'b0;
         in_range_q   <= 1'b0;
         wb_ack_q     <= 1'b0;
         wb_err_q     <= 1'b0;
         wb_rd_data_q <= '0;
      end else begin
         wb_ack_q <= fin & fin_ok;
         wb_err_q <= fin & ~fin_ok;
         if (fin && !fin_wr) wb_rd_data_q <= wb_rd_data_d;

         case (state_q)
            MEM_IDLE: begin
               if (accept && (DATA_LATENCY > 1)) begin
                  idx_q      <= wb_idx;
                  wr_en_q    <= wb_wr_en;
                  in_range_q <= wb_ok;
                  cnt_q      <= CNT_W'(DATA_LATENCY - 1);
                  state_q    <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               // Dropping wb_cyc abandons the access silently.
               if (!wb_cyc || fin) begin
                  cnt_q   <= '0;
                  state_q <= MEM_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= MEM_IDLE;
         endcase
      end
   end

   assign instr      = instr_q;
   assign instr_ack  = instr_ack_q;
   assign instr_err  = instr_err_q;
   assign wb_ack     = wb_ack_q;
   assign wb_err     = wb_err_q;
   assign wb_rd_data = wb_rd_data_q;

endmodule

// File: tb/tb_wb_wait_memory.sv
// Randomised self-checking bench for wb_wait_memory against a word-array model.
module tb_wb_wait_memory;

   localparam int unsigned MB    = 1000;
   localparam int unsigned LAT   = 3;
   localparam int unsigned AW    = 32;
   localparam int unsigned WORDS = MB / 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] instr_addr;
   logic          instr_stb;
   logic [31:0]   instr;
   logic          instr_ack;
   logic          instr_err;
   logic          wb_cyc;
   logic          wb_stb;
   logic          wb_wr_en;
   logic [AW-1:0] wb_addr;
   logic [31:0]   wb_wr_data;
   logic [3:0]    wb_wr_sel;
   logic          wb_ack;
   logic          wb_err;
   logic          wb_stall;
   logic [31:0]   wb_rd_data;

   logic [31:0] ref_mem [WORDS];
   logic [31:0] ref_rd;
   bit          instr_chk;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   wb_wait_memory #(
      .MEMORY_BYTES (MB),
      .ADDR_WIDTH   (AW),
      .DATA_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_addr (instr_addr),
      .instr_stb  (instr_stb),
      .instr      (instr),
      .instr_ack  (instr_ack),
      .instr_err  (instr_err),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_wr_en   (wb_wr_en),
      .wb_addr    (wb_addr),
      .wb_wr_data (wb_wr_data),
      .wb_wr_sel  (wb_wr_sel),
      .wb_ack     (wb_ack),
      .wb_err     (wb_err),
      .wb_stall   (wb_stall),
      .wb_rd_data (wb_rd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit addr_ok(input logic [31:0] a);
      return a < MB;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(0, MB + 63));
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
      if (addr_ok(a)) begin
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[int'(a >> 2)][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   // One clock: predict the instruction port from pre-edge memory, advance, compare.
   task automatic step();
      logic [31:0] e_instr;
      logic        e_ack;
      logic        e_err;
      e_ack   = instr_stb;
      e_err   = instr_stb & ~addr_ok(instr_addr);
      e_instr = addr_ok(instr_addr) ? ref_mem[int'(instr_addr >> 2)] : 32'h0;
      @(posedge clk);
      @(negedge clk);
      if (instr_chk) begin
         check("instr", instr, e_instr);
         check("instr_ack", 32'(instr_ack), 32'(e_ack));
         check("instr_err", 32'(instr_err), 32'(e_err));
         instr_stb  = 1'($urandom_range(0, 1));
         instr_addr = rand_addr();
      end
   endtask

   // Full data access starting in an idle cycle; ends at the negedge of the ack cycle.
   task automatic bus_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sel);
      bit ok;
      ok = addr_ok(a);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_wr_en = we;
      wb_addr = a; wb_wr_data = d; wb_wr_sel = sel;
      check("stall_idle", 32'(wb_stall), 32'h0);
      step();
      if (we) model_write(a, d, sel);
      else    ref_rd = ok ? ref_mem[int'(a >> 2)] : 32'h0;
      wb_stb = 1'b0;
      wb_wr_en = 1'($urandom_range(0, 1));
      wb_addr = $urandom;
      wb_wr_data = $urandom;
      for (int n = 1; n < LAT; n++) begin
         check("stall_wait", 32'(wb_stall), 32'h1);
         check("ack_early", 32'({wb_ack, wb_err}), 32'h0);
         step();
      end
      check("ack", 32'(wb_ack), 32'(ok));
      check("err", 32'(wb_err), 32'(!ok));
      check("rd_data", wb_rd_data, ref_rd);
      check("stall_done", 32'(wb_stall), 32'h0);
   endtask

   // Accept an access, then drop wb_cyc one cycle into the wait.
   task automatic cancel_op(input logic we, input logic [31:0] a, input logic [31:0] d);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_wr_en = we;
      wb_addr = a; wb_wr_data = d; wb_wr_sel = 4'hF;
      step();
      if (we) model_write(a, d, 4'hF);
      wb_stb = 1'b0;
      check("cancel_stall_wait", 32'(wb_stall), 32'h1);
      wb_cyc = 1'b0;
      step();
      check("cancel_stall", 32'(wb_stall), 32'h0);
      check("cancel_ackerr", 32'({wb_ack, wb_err}), 32'h0);
      check("cancel_rd", wb_rd_data, ref_rd);
      for (int n = 0; n < LAT; n++) begin
         step();
         check("cancel_quiet", 32'({wb_ack, wb_err}), 32'h0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; instr_chk = 1'b0;
      instr_addr = '0; instr_stb = 1'b0;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_wr_en = 1'b0;
      wb_addr = '0; wb_wr_data = '0; wb_wr_sel = '0;
      ref_rd = '0;

      // Reset state
      #12;
      check("rst_instr", instr, 32'h0);
      check("rst_instr_ack", 32'(instr_ack), 32'h0);
      check("rst_instr_err", 32'(instr_err), 32'h0);
      check("rst_ack", 32'(wb_ack), 32'h0);
      check("rst_err", 32'(wb_err), 32'h0);
      check("rst_stall", 32'(wb_stall), 32'h0);
      check("rst_rd", wb_rd_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill every word so the model is fully defined
      for (int i = 0; i < int'(WORDS); i++) begin
         logic [31:0] v;
         v = $urandom;
         if (i == 'h30/4 || i == 'h40/4) v = 32'h0;
         if (i == 'h34/4) v = 32'h0000_00CD;
         bus_op(1'b1, 32'(i * 4), v, 4'hF);
      end
      instr_chk = 1'b1;

      // Byte-lane write then read back
      bus_op(1'b1, 32'h30, 32'hABCD_EF01, 4'b0100);
      bus_op(1'b0, 32'h30, 32'h0, 4'h0);
      check("t1_rd", wb_rd_data, 32'h00CD_0000);

      // Preloaded read, back-to-back follow-up
      bus_op(1'b0, 32'h34, 32'h0, 4'h0);
      check("t2_rd", wb_rd_data, 32'h0000_00CD);
      bus_op(1'b0, 32'h30, 32'h0, 4'h0);

      // Out-of-range write and read, top in-range word untouched
      bus_op(1'b1, 32'h3E8, 32'hFFFF_FFFF, 4'hF);
      bus_op(1'b0, 32'h3E4, 32'h0, 4'h0);
      bus_op(1'b0, 32'h3E8, 32'h0, 4'h0);
      check("t3_rd_oor", wb_rd_data, 32'h0);

      // Cancellation of a read and of a committed write
      cancel_op(1'b0, 32'h34, 32'h0);
      bus_op(1'b0, 32'h34, 32'h0, 4'h0);
      cancel_op(1'b1, 32'h50, 32'h5A5A_1234);
      bus_op(1'b0, 32'h50, 32'h0, 4'h0);
      check("t4_cancel_wr", wb_rd_data, 32'h5A5A_1234);

      // Strobe without cycle is ignored
      wb_cyc = 1'b0; wb_stb = 1'b1; wb_wr_en = 1'b1;
      wb_addr = 32'h30; wb_wr_data = 32'hDEAD_BEEF; wb_wr_sel = 4'hF;
      step();
      check("nocyc_stall", 32'(wb_stall), 32'h0);
      step();
      check("nocyc_ackerr", 32'({wb_ack, wb_err}), 32'h0);
      bus_op(1'b0, 32'h30, 32'h0, 4'h0);

      // Instruction read and data write to the same word on the same edge
      instr_stb = 1'b1; instr_addr = 32'h40;
      bus_op(1'b1, 32'h40, 32'h1122_3344, 4'hF);
      instr_stb = 1'b1; instr_addr = 32'h40;
      step();
      check("t5_instr_new", instr, 32'h1122_3344);

      // Asynchronous reset in the middle of a wait
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_wr_en = 1'b0; wb_addr = 32'h34;
      step();
      wb_stb = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_stall", 32'(wb_stall), 32'h0);
      check("t6_ackerr", 32'({wb_ack, wb_err}), 32'h0);
      check("t6_rd", wb_rd_data, 32'h0);
      check("t6_instr", instr, 32'h0);
      check("t6_instr_flags", 32'({instr_ack, instr_err}), 32'h0);
      ref_rd = 32'h0;
      wb_cyc = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus_op(1'b0, 32'h40, 32'h0, 4'h0);
      check("t6_rd_after", wb_rd_data, 32'h1122_3344);

      // Random traffic with occasional idle cycles
      for (int k = 0; k < 300; k++) begin
         bus_op(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            wb_stb = 1'b0;
            wb_cyc = 1'($urandom_range(0, 1));
            step();
            check("idle_ackerr", 32'({wb_ack, wb_err}), 32'h0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
